sr_fun_arbiter: RTL and testbench
=================================

# sr_fun_arbiter

Shares the single multi-cycle function unit (`func`, start/busy handshake, 8-bit operands, 25-bit result) between two requesters: the CPU core port and a second port for a debug or accelerator master. It latches the operands and issues `start`, then waits for `busy` to drop, captures the result and returns it with a one-cycle `done` pulse. Round-robin arbitration prevents either port from starving the other. The block sits between `sr_cpu` and `func` and replaces the single-requester start/busy sequencer.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum number of WAIT cycles before an abort. Used only when the timeout feature is compiled in.
- `clk` in 1: clock
- `reset` in 1: synchronous, active-low reset
- `req0` / `req1` in 1: requester operation request. Operands must be held stable while `req` is high.
- `a0`, `b0` / `a1`, `b1` in 8 each: requester operands
- `done0` / `done1` out 1: one-cycle completion pulse to the granted requester
- `y0` / `y1` out 25: result register. Valid while `done` is high and held until that port's next `done`.
- `err` out 1: one-cycle pulse together with `done` when an operation times out
- `grant` out 1: id of the port that currently owns the unit, or last owned it
- `fu_start` out 1: start strobe to `func`
- `fu_a`, `fu_b` out 8 each: latched operands to `func`
- `fu_busy` in 1: busy flag from `func`
- `fu_y` in 25: result from `func`
- `fu_abort` out 1: one-cycle reset request to `func`. The top level ORs it into the `func` reset.

## Operation
- FSM states: IDLE → START → WAIT → DONE → IDLE. Encodings are two bits and come from the shared header.
- **IDLE**
  - If neither request is high, stay in IDLE.
  - Otherwise pick a winner: if only one request is high, that port wins; if both are high, the port that is not `grant` wins.
  - Latch the winner's operands into `fu_a`/`fu_b`, set `grant`, and go to START.
- **START**
  - `fu_start` = 1, driven combinationally from the state, for exactly one cycle.
  - Go to WAIT.
- **WAIT**
  - While `fu_busy` = 1, stay in WAIT.
  - When `fu_busy` = 0, capture `fu_y` into the granted port's `y` register and go to DONE.
  - `func` raises `busy` on the edge that samples `start`, so the first WAIT cycle already sees `busy` = 1.
- **DONE**
  - `done[grant]` = 1 for one cycle.
  - Go to IDLE.
- **Request dropped mid-operation:** the operation still completes and `done` still pulses. The requester ignores it.
- **Back-to-back:** a port holding `req` high after its `done` re-requests in the next IDLE. If the other port is also requesting, the other port wins.
- **Data width:** `y` is a straight 25-bit copy of `fu_y`. There is no extension or truncation.

## Timing
- **Reset values:** state = IDLE; `done0`, `done1`, `err`, `fu_start`, `fu_abort` = 0; `y0`, `y1`, `fu_a`, `fu_b` = 0.
- **Reset values (arbitration):** `grant` = 1, so port 0 wins the first contested arbitration.
- **Reset mid-operation:** returns to IDLE on the next edge with no `done` pulse. The system reset also resets `func`.
- **Latency:** with `req` sampled in IDLE at cycle 0 and `busy` high for B cycles, `done` is high at cycle B+3.
- **Throughput:** one operation every B+4 cycles, because IDLE costs one cycle between operations.
- **Arbitration hold:** a request that arrives during START, WAIT or DONE waits for the next IDLE.
- **Single-cycle `done`:** `done0` and `done1` are never high in the same cycle.

## Configuration
- `SR_FUN_ARB_TIMEOUT_EN` defined:
  - A WAIT-cycle counter is reset on entry to START.
  - When the counter reaches `TIMEOUT_CYCLES` while `fu_busy` = 1:
    - `fu_abort` = 1 for one cycle;
    - the granted `y` is loaded with 25'h1FFFFFF;
    - the FSM goes to DONE, where `err` = 1 alongside `done`.
- `SR_FUN_ARB_TIMEOUT_EN` undefined:
  - There is no counter.
  - `err` and `fu_abort` are tied to 0.
  - WAIT waits indefinitely.

## Structure
- Shared header `sr_cpu.vh` holds:
  - the FSM state encodings `FUNARB_IDLE`, `FUNARB_START`, `FUNARB_WAIT`, `FUNARB_DONE`;
  - the widths `FUN_OP_W` = 8 and `FUN_RES_W` = 25;
  - the timeout sentinel value.
- One sub-module, `sr_rr_arb2`: a combinational two-way round-robin pick with inputs `req[1:0]` and `last`, and output `win`.

## Test plan
The bench uses a `func` model that holds `busy` for 4 cycles and returns y = a*b.
- `req0` with a=3, b=5 → `fu_start` at cycle 1, `done0` at cycle 7, `y0` = 15; `done1` stays 0.
- `req0` and `req1` high together after reset, with (2,7) and (9,9) → port 0 is served first with `y0` = 14; then port 1 with `y1` = 81, whose `done1` arrives 8 cycles after `done0`.
- Both requests held high → grants alternate 0, 1, 0, 1 over four operations.
- `reset` driven low during WAIT → state is IDLE on the next cycle, no `done` pulse, all outputs are at their reset values.
- With the macro defined, `TIMEOUT_CYCLES` = 8 and `busy` stuck high → `fu_abort` pulses; `done0` and `err` go high together 11 cycles after `req0`; `y0` = 0x1FFFFFF.
- `req1` dropped during WAIT → `done1` still pulses, and the next operation runs normally.

Source files
------------

// File: rtl/sr_fun_arbiter_pkg.sv
// sr_fun_arbiter_pkg
// Shared definitions for the function-unit arbiter slice: FSM state
// encodings, operand/result widths and the result value reported when
// an operation is aborted by the timeout.
// No ports (package).

package sr_fun_arbiter_pkg;

    localparam int FUN_OP_W  = 8;
    localparam int FUN_RES_W = 25;

    // All-ones result marks an operation that was aborted.
    localparam logic [FUN_RES_W-1:0] FUN_TIMEOUT_Y = {FUN_RES_W{1'b1}};

    typedef enum logic [1:0] {
        FUNARB_IDLE  = 2'd0,
        FUNARB_START = 2'd1,
        FUNARB_WAIT  = 2'd2,
        FUNARB_DONE  = 2'd3
    } funarb_state_t;

endpackage

// File: rtl/sr_fun_arbiter_if.sv
// sr_fun_arbiter_if
// Start/busy handshake bus between the arbiter and the shared function
// unit `func`.
//   start : one-cycle start strobe to func
//   a, b  : latched operands to func
//   abort : one-cycle reset request to func (timeout)
//   busy  : busy flag from func
//   y     : result from func
// Modports: master = arbiter side, slave = function-unit side.

interface sr_fun_arbiter_if;
    import sr_fun_arbiter_pkg::*;

    logic                 start;
    logic [FUN_OP_W-1:0]  a;
    logic [FUN_OP_W-1:0]  b;
    logic                 abort;
    logic                 busy;
    logic [FUN_RES_W-1:0] y;

    modport master (output start, a, b, abort, input busy, y);
    modport slave  (input start, a, b, abort, output busy, y);

endinterface

// File: rtl/sr_rr_arb2.sv
// sr_rr_arb2
// Combinational two-way round-robin pick.
//   req[1:0] : request lines of port 0 and port 1
//   last     : id of the port that owned the resource most recently
//   win      : id of the winning port (only meaningful when a request is up)

module sr_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       win
);

    // A lone requester always wins; on contention the port that did not
    // go last gets its turn.
    always_comb begin
        win = last;
        case (req)
            2'b01:   win = 1'b0;
            2'b10:   win = 1'b1;
            2'b11:   win = ~last;
            default: win = last;
        endcase
    end

endmodule

// File: rtl/sr_fun_arbiter.sv
// sr_fun_arbiter
// Shares one multi-cycle function unit between two requesters (CPU core
// port 0, debug/accelerator port 1) with round-robin arbitration.
// Sequence per operation: IDLE -> START -> WAIT -> DONE -> IDLE.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   req0/req1           : operation requests (operands held while high)
//   a0,b0 / a1,b1       : requester operands
//   done0/done1         : one-cycle completion pulse to the served port
//   y0/y1               : per-port result registers, held until next done
//   err                 : pulses with done when an operation timed out
//   grant               : port that owns, or last owned, the unit
//   fu                  : start/busy bus to func (master side)
// Parameter TIMEOUT_CYCLES: WAIT-cycle limit, used only when the macro
// SR_FUN_ARB_TIMEOUT_EN is defined. Without it err and fu.abort stay 0
// and WAIT waits indefinitely.

module sr_fun_arbiter
    import sr_fun_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic [FUN_OP_W-1:0]   a0,
    input  logic [FUN_OP_W-1:0]   b0,
    input  logic [FUN_OP_W-1:0]   a1,
    input  logic [FUN_OP_W-1:0]   b1,
    output logic                  done0,
    output logic                  done1,
    output logic [FUN_RES_W-1:0]  y0,
    output logic [FUN_RES_W-1:0]  y1,
    output logic                  err,
    output logic                  grant,
    sr_fun_arbiter_if.master      fu
);

    funarb_state_t       state;
    logic                win;
    logic                timed_out;
    logic                abort_q;
    logic [FUN_OP_W-1:0] fu_a_q;
    logic [FUN_OP_W-1:0] fu_b_q;

    sr_rr_arb2 u_rr (
        .req  ({req1, req0}),
        .last (grant),
        .win  (win)
    );

    assign fu.start = (state == FUNARB_START);
    assign fu.a     = fu_a_q;
    assign fu.b     = fu_b_q;
    assign fu.abort = abort_q;

`ifdef SR_FUN_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Counts WAIT cycles of the current operation; cleared in START so the
    // first WAIT cycle sees zero. Saturates at the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == FUNARB_START) begin
            wait_cnt <= '0;
        end else if (state == FUNARB_WAIT && wait_cnt != CNT_W'(TIMEOUT_CYCLES)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timed_out = fu.busy && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    // Keeps the parameter referenced in the build without the timeout.
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign timed_out      = 1'b0;
`endif

    // Main sequencer. done/err/abort are registered and raised on the
    // transition into DONE, so they are high exactly during the DONE cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FUNARB_IDLE;
            grant   <= 1'b1;
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            abort_q <= 1'b0;
            y0      <= '0;
            y1      <= '0;
            fu_a_q  <= '0;
            fu_b_q  <= '0;
        end else begin
            done0   <= 1'b0;
            done1   <= 1'b0;
            err     <= 1'b0;
            abort_q <= 1'b0;
            case (state)
                FUNARB_IDLE: begin
                    if (req0 || req1) begin
                        grant  <= win;
                        fu_a_q <= win ? a1 : a0;
                        fu_b_q <= win ? b1 : b0;
                        state  <= FUNARB_START;
                    end
                end
                FUNARB_START: begin
                    state <= FUNARB_WAIT;
                end
                FUNARB_WAIT: begin
                    if (timed_out) begin
                        abort_q <= 1'b1;
                        err     <= 1'b1;
                        if (grant) begin
                            y1    <= FUN_TIMEOUT_Y;
                            done1 <= 1'b1;
                        end else begin
                            y0    <= FUN_TIMEOUT_Y;
                            done0 <= 1'b1;
                        end
                        state <= FUNARB_DONE;
                    end else if (!fu.busy) begin
                        if (grant) begin
                            y1    <= fu.y;
                            done1 <= 1'b1;
                        end else begin
                            y0    <= fu.y;
                            done0 <= 1'b1;
                        end
                        state <= FUNARB_DONE;
                    end
                end
                FUNARB_DONE: begin
                    state <= FUNARB_IDLE;
                end
                default: begin
                    state <= FUNARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_fun_arbiter.sv
// tb_sr_fun_arbiter
// Scoreboard bench for sr_fun_arbiter. A func model returns a*b after a
// programmable number of busy cycles; the stimulus side predicts each
// completion (port, result, err flag, cycle) from the arbitration rules and
// queues it, and a monitor checks every done pulse against the queue.

module tb_sr_fun_arbiter;
    import sr_fun_arbiter_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [7:0]  a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic        done0, done1, err, grant;
    logic [24:0] y0, y1;

    sr_fun_arbiter_if fu_bus ();

    sr_fun_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .a0    (a0),
        .b0    (b0),
        .a1    (a1),
        .b1    (b1),
        .done0 (done0),
        .done1 (done1),
        .y0    (y0),
        .y1    (y1),
        .err   (err),
        .grant (grant),
        .fu    (fu_bus.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Function unit model: busy rises on the edge that samples start and
    // stays high for busy_len cycles; stuck holds it high until an abort.
    int busy_len = 4;
    bit stuck = 1'b0;
    int fu_cnt = 0;
    always @(posedge clk) begin
        if (!reset || fu_bus.abort) begin
            fu_bus.busy <= 1'b0;
            fu_cnt      <= 0;
        end else if (fu_bus.start) begin
            fu_bus.busy <= 1'b1;
            fu_cnt      <= busy_len - 1;
            fu_bus.y    <= {17'd0, fu_bus.a} * {17'd0, fu_bus.b};
        end else if (fu_bus.busy && !stuck) begin
            if (fu_cnt == 0) fu_bus.busy <= 1'b0;
            else             fu_cnt <= fu_cnt - 1;
        end
    end

    typedef struct {
        bit          port;
        logic [24:0] y;
        bit          e;
        int          c;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   last_win = 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
                     name, actual, required, cyc);
        end
    endtask

    task automatic pushExp(input int port, input int prod, input bit e, input int c);
        exp_t x;
        x.port = port[0];
        x.y    = e ? FUN_TIMEOUT_Y : 25'(prod);
        x.e    = e;
        x.c    = c;
        exp_q.push_back(x);
    endtask

    // Monitor: every done pulse is matched against the oldest prediction.
    exp_t m;
    always @(negedge clk) begin
        if (reset && (done0 || done1)) begin
            checkOutput("single_done", {31'd0, done0 & done1}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_done: got done0=%0b done1=%0b, want none (cycle %0d)",
                         done0, done1, cyc);
            end else begin
                m = exp_q.pop_front();
                checkOutput("done_port", {31'd0, done1}, {31'd0, m.port});
                checkOutput("grant", {31'd0, grant}, {31'd0, m.port});
                checkOutput("y", {7'd0, (done1 ? y1 : y0)}, {7'd0, m.y});
                checkOutput("err", {31'd0, err}, {31'd0, m.e});
                checkOutput("fu_abort", {31'd0, fu_bus.abort}, {31'd0, m.e});
                checkOutput("done_cycle", cyc, m.c);
            end
        end
    end

    task automatic waitDone(output int which);
        which = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done0) begin which = 0; return; end
            if (done1) begin which = 1; return; end
        end
        total++;
        bad++;
        $display("[TB] FAIL done_timeout: got no done in 300 cycles, want one (cycle %0d)", cyc);
    endtask

    task automatic dropPort(input int which);
        if (which != 1) req0 = 1'b0;
        if (which != 0) req1 = 1'b0;
    endtask

    // mode 0/1: single port; 2: both once each; 3: both held for four ops;
    // 4: port 1 drops its request while the operation is in WAIT.
    task automatic applyStimulus(input int mode, input logic [7:0] x0, input logic [7:0] z0,
                                 input logic [7:0] x1, input logic [7:0] z1, input int blen);
        int p, w, first, pr0, pr1;
        @(negedge clk);
        busy_len = blen;
        p   = cyc;
        pr0 = int'(x0) * int'(z0);
        pr1 = int'(x1) * int'(z1);
        a0 = x0; b0 = z0; a1 = x1; b1 = z1;
        case (mode)
            0: begin
                pushExp(0, pr0, 0, p + blen + 3);
                req0 = 1'b1;
                waitDone(w);
                dropPort(-1);
                last_win = 0;
            end
            1, 4: begin
                pushExp(1, pr1, 0, p + blen + 3);
                req1 = 1'b1;
                if (mode == 4) begin
                    repeat (2) @(negedge clk);
                    req1 = 1'b0;
                    a1 = 8'($urandom_range(0, 255));
                    b1 = 8'($urandom_range(0, 255));
                end
                waitDone(w);
                dropPort(-1);
                last_win = 1;
            end
            2: begin
                first = (last_win == 0) ? 1 : 0;
                pushExp(first, first ? pr1 : pr0, 0, p + blen + 3);
                pushExp(1 - first, first ? pr0 : pr1, 0, p + 2 * blen + 7);
                req0 = 1'b1;
                req1 = 1'b1;
                waitDone(w);
                dropPort(w);
                waitDone(w);
                dropPort(-1);
                last_win = 1 - first;
            end
            default: begin
                first = (last_win == 0) ? 1 : 0;
                for (int k = 0; k < 4; k++) begin
                    pushExp(first ^ (k & 1), (first ^ (k & 1)) ? pr1 : pr0, 0,
                            p + blen + 3 + k * (blen + 4));
                end
                req0 = 1'b1;
                req1 = 1'b1;
                for (int k = 0; k < 4; k++) waitDone(w);
                dropPort(-1);
                last_win = 1 - first;
            end
        endcase
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_done0"}, {31'd0, done0}, 32'd0);
        checkOutput({tag, "_done1"}, {31'd0, done1}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
        checkOutput({tag, "_fu_start"}, {31'd0, fu_bus.start}, 32'd0);
        checkOutput({tag, "_fu_abort"}, {31'd0, fu_bus.abort}, 32'd0);
        checkOutput({tag, "_y0"}, {7'd0, y0}, 32'd0);
        checkOutput({tag, "_y1"}, {7'd0, y1}, 32'd0);
        checkOutput({tag, "_fu_a"}, {24'd0, fu_bus.a}, 32'd0);
        checkOutput({tag, "_fu_b"}, {24'd0, fu_bus.b}, 32'd0);
        checkOutput({tag, "_grant"}, {31'd0, grant}, 32'd1);
    endtask

    initial begin
        int p, w;
        repeat (3) @(negedge clk);
        checkResetValues("rst");
        reset = 1'b1;

        // Contested first arbitration after reset: port 0 first.
        applyStimulus(2, 8'd2, 8'd7, 8'd9, 8'd9, 4);

        // Single request: start strobe one cycle after sampling.
        @(negedge clk);
        busy_len = 4;
        p  = cyc;
        a0 = 8'd3; b0 = 8'd5;
        req0 = 1'b1;
        pushExp(0, 15, 0, p + 7);
        @(negedge clk);
        checkOutput("fu_start_c1", {31'd0, fu_bus.start}, 32'd1);
        checkOutput("fu_a_c1", {24'd0, fu_bus.a}, 32'd3);
        checkOutput("fu_b_c1", {24'd0, fu_bus.b}, 32'd5);
        waitDone(w);
        req0 = 1'b0;
        last_win = 0;

        // Held requests alternate, then port 1 drops its request mid-op.
        applyStimulus(3, 8'd11, 8'd13, 8'd200, 8'd250, 4);
        applyStimulus(4, 8'd0, 8'd0, 8'd17, 8'd19, 4);
        applyStimulus(0, 8'd255, 8'd255, 8'd0, 8'd0, 2);

        // Reset asserted while WAIT: no done, everything back to reset values.
        @(negedge clk);
        busy_len = 4;
        a0 = 8'd6; b0 = 8'd7;
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        @(negedge clk);
        checkResetValues("midrst");
        reset = 1'b1;
        last_win = 1;
        repeat (8) @(negedge clk);

`ifdef SR_FUN_ARB_TIMEOUT_EN
        // Busy stuck high: aborted with the sentinel result and err.
        @(negedge clk);
        stuck = 1'b1;
        p  = cyc;
        a0 = 8'd4; b0 = 8'd4;
        req0 = 1'b1;
        pushExp(0, 0, 1, p + TMO + 3);
        waitDone(w);
        req0  = 1'b0;
        stuck = 1'b0;
        last_win = 0;
`endif

        for (int i = 0; i < 20; i++) begin
            applyStimulus($urandom_range(0, 4),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          $urandom_range(1, 6));
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d outstanding completions, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
